// File: rtl/load_store_unit_if.sv
// Word-aligned request/acknowledge data bus between the load/store unit and memory.
interface load_store_unit_if;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic [3:0]  BusByteEn;
    logic [31:0] BusRData;
    logic        BusAck;

    modport master (
        output BusReq, BusWe, BusAddr, BusWData, BusByteEn,
        input  BusRData, BusAck
    );

    modport slave (
        input  BusReq, BusWe, BusAddr, BusWData, BusByteEn,
        output BusRData, BusAck
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: IDLE/BUSY/DONE bus sequencer with lane steering.
// Optional `LSU_TIMEOUT_EN aborts a BUSY access after TIMEOUT_CYCLES cycles without ack.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    load_store_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic        req_q, we_q, ld_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;

    logic        access, illegal, misal, legal;
    logic [1:0]  a;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, rdata_d;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign access = MemReadM | MemWriteM;
    assign a      = ALUOutM[1:0];

    // A load+store collision is a store, so legality follows the store table.
    always_comb begin
        if (MemWriteM) illegal = Funct3M[2] | (Funct3M[1:0] == 2'b11);
        else           illegal = (Funct3M[1:0] == 2'b11) | (Funct3M[2:1] == 2'b11);
        case (Funct3M[1:0])
            2'b01:   misal = a[0];
            2'b10:   misal = (a != 2'b00);
            default: misal = 1'b0;
        endcase
    end

    assign MisalignM = access & (misal | illegal);
    assign legal     = access & ~(misal | illegal);
    assign StallM    = ((state_q == IDLE) & legal) | (state_q == BUSY);

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << a;
                    wdata_d = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    be_d    = a[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{WriteDataM[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = WriteDataM;
                end
            endcase
        end
    end

    // Offset and size are captured at issue so the return path does not depend on the EX/MEM register.
    always_comb begin
        rbyte = bus.BusRData[8*off_q +: 8];
        rhalf = off_q[1] ? bus.BusRData[31:16] : bus.BusRData[15:0];
        case (f3_q)
            3'b000:  rdata_d = {{24{rbyte[7]}}, rbyte};
            3'b001:  rdata_d = {{16{rhalf[15]}}, rhalf};
            3'b100:  rdata_d = {24'h0, rbyte};
            3'b101:  rdata_d = {16'h0, rhalf};
            default: rdata_d = bus.BusRData;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            off_q   <= '0;
            f3_q    <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (legal) begin
                    req_q   <= 1'b1;
                    we_q    <= MemWriteM;
                    ld_q    <= ~MemWriteM;
                    addr_q  <= {ALUOutM[31:2], 2'b00};
                    wdata_q <= wdata_d;
                    be_q    <= be_d;
                    off_q   <= a;
                    f3_q    <= Funct3M;
                    state_q <= BUSY;
`ifdef LSU_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                BUSY: begin
                    if (bus.BusAck) begin
                        req_q   <= 1'b0;
                        if (ld_q) rdata_q <= rdata_d;
                        state_q <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        req_q   <= 1'b0;
                        if (ld_q) rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    assign BusErrM = err_q;
`else
    assign BusErrM = 1'b0;
`endif

    assign ReadDataM     = rdata_q;
    assign bus.BusReq    = req_q;
    assign bus.BusWe     = we_q;
    assign bus.BusAddr   = addr_q;
    assign bus.BusWData  = wdata_q;
    assign bus.BusByteEn = be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected bus requests and completions.
module tb_load_store_unit;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          chk_wd;
    } bus_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stall;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  Funct3M = '0;
    logic [31:0] ALUOutM = '0, WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;

    bus_t bus_q[$];
    res_t res_q[$];
    int   n_cmp = 0, n_bad = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
        .BusErrM(BusErrM), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected request on BusReq rise, expected result when a stall run ends.
    initial begin
        logic prev_req;
        int   stall_cnt;
        bus_t cur, eb;
        res_t er;
        prev_req = 1'b0;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                stall_cnt = 0;
            end else begin
                if (bus.BusReq && !prev_req) begin
                    cur = '{bus.BusWe, bus.BusAddr, bus.BusByteEn, bus.BusWData, 1'b1};
                    if (bus_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                    else begin
                        eb = bus_q.pop_front();
                        chk("BusWe", {31'd0, bus.BusWe}, {31'd0, eb.we});
                        chk("BusAddr", bus.BusAddr, eb.addr);
                        chk("BusByteEn", {28'd0, bus.BusByteEn}, {28'd0, eb.be});
                        if (eb.chk_wd) chk("BusWData", bus.BusWData, eb.wd);
                    end
                end else if (bus.BusReq) begin
                    chk("bus_stable", {bus.BusWe, bus.BusByteEn, bus.BusAddr[26:0] ^ bus.BusWData[26:0]},
                        {cur.we, cur.be, cur.addr[26:0] ^ cur.wd[26:0]});
                end
                if (StallM) stall_cnt++;
                else if (stall_cnt > 0) begin
                    if (res_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                    else begin
                        er = res_q.pop_front();
                        chk("ReadDataM", ReadDataM, er.rd);
                        chk("BusErrM", {31'd0, BusErrM}, {31'd0, er.err});
                        chk("stall_cycles", stall_cnt, er.stall);
                    end
                    stall_cnt = 0;
                end
                prev_req = bus.BusReq;
            end
        end
    end

    // dly < 0: never acknowledge.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                             input int dly, input logic ewe, input logic [31:0] eaddr,
                             input logic [3:0] ebe, input logic [31:0] ewd, input bit chkwd,
                             input logic [31:0] erd, input logic eerr, input int estall);
        int k;
        bus_q.push_back('{ewe, eaddr, ebe, ewd, chkwd});
        res_q.push_back('{erd, eerr, estall});
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUOutM = addr; WriteDataM = wd;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!bus.BusReq && k < 20);
        if (!bus.BusReq) chk("req_wait_timeout", 32'd0, 32'd1);
        k = 0;
        while (bus.BusReq && k < 40) begin
            if (k == dly) begin bus.BusAck = 1'b1; bus.BusRData = rdata; end
            @(posedge clk); #1;
            bus.BusAck = 1'b0; bus.BusRData = 32'hAAAA_AAAA;
            k++;
        end
        if (bus.BusReq) chk("ack_wait_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    task automatic bad_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] erd);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUOutM = addr;
        #1;
        chk("MisalignM", {31'd0, MisalignM}, 32'd1);
        chk("mis_StallM", {31'd0, StallM}, 32'd0);
        @(posedge clk); #1;
        chk("mis_BusReq", {31'd0, bus.BusReq}, 32'd0);
        chk("mis_ReadDataM", ReadDataM, erd);
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.BusAck = 1'b0;
        bus.BusRData = 32'hAAAA_AAAA;
        #12;
        chk("rst_ReadDataM", ReadDataM, 32'h0);
        chk("rst_BusReq", {31'd0, bus.BusReq}, 32'd0);
        chk("rst_BusAddr", bus.BusAddr, 32'h0);
        chk("rst_BusByteEn", {28'd0, bus.BusByteEn}, 32'd0);
        chk("rst_StallM", {31'd0, StallM}, 32'd0);
        chk("rst_BusErrM", {31'd0, BusErrM}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'h100, 4'hF, 0, 0, 32'hDEADBEEF, 0, 2);
        do_access(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0, 0, 32'h200, 4'hF, 0, 0, 32'hFFFFFF80, 0, 2);
        do_access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 0, 0, 32'h200, 4'hF, 0, 0, 32'h00000080, 0, 2);
        do_access(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 0, 1, 32'h300, 4'b1100, 32'hABCDABCD, 1, 32'h00000080, 0, 2);
        do_access(0, 1, 3'b000, 32'h001, 32'h00000055, 32'h0, 1, 1, 32'h000, 4'b0010, 32'h55555555, 1, 32'h00000080, 0, 3);
        do_access(1, 1, 3'b010, 32'h010, 32'hCAFEF00D, 32'h0, 0, 1, 32'h010, 4'hF, 32'hCAFEF00D, 1, 32'h00000080, 0, 2);
        do_access(1, 0, 3'b001, 32'h042, 32'h0, 32'h80017FFF, 2, 0, 32'h040, 4'hF, 0, 0, 32'hFFFF8001, 0, 4);
        do_access(1, 0, 3'b101, 32'h040, 32'h0, 32'h80017FFF, 0, 0, 32'h040, 4'hF, 0, 0, 32'h00007FFF, 0, 2);

        bad_access(1, 0, 3'b010, 32'h101, 32'h00007FFF);
        bad_access(1, 0, 3'b011, 32'h000, 32'h00007FFF);
        bad_access(0, 1, 3'b001, 32'h301, 32'h00007FFF);
        bad_access(0, 1, 3'b100, 32'h300, 32'h00007FFF);

        // Stray ack with no access in flight.
        bus.BusAck = 1'b1; bus.BusRData = 32'h11111111;
        repeat (2) @(posedge clk); #1;
        bus.BusAck = 1'b0;
        chk("stray_BusReq", {31'd0, bus.BusReq}, 32'd0);
        chk("stray_ReadDataM", ReadDataM, 32'h00007FFF);

        // LH with a slow ack, reset hits in the third BUSY cycle.
        bus_q.push_back('{1'b0, 32'h40, 4'hF, 32'h0, 1'b0});
        MemReadM = 1'b1; Funct3M = 3'b001; ALUOutM = 32'h40;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_BusReq", {31'd0, bus.BusReq}, 32'd1);
        #1;
        rst_n = 1'b0; MemReadM = 1'b0;
        #1;
        chk("midrst_BusReq", {31'd0, bus.BusReq}, 32'd0);
        chk("midrst_StallM", {31'd0, StallM}, 32'd0);
        chk("midrst_BusAddr", bus.BusAddr, 32'h0);
        chk("midrst_BusByteEn", {28'd0, bus.BusByteEn}, 32'd0);
        chk("midrst_ReadDataM", ReadDataM, 32'h0);
        #10;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("postrst_BusReq", {31'd0, bus.BusReq}, 32'd0);

        do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 0, 0, 32'h100, 4'hF, 0, 0, 32'h0BADF00D, 0, 2);
`ifdef LSU_TIMEOUT_EN
        do_access(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, -1, 0, 32'h400, 4'hF, 0, 0, 32'h0, 1, 5);
        do_access(1, 0, 3'b010, 32'h400, 32'h0, 32'h12345678, 3, 0, 32'h400, 4'hF, 0, 0, 32'h12345678, 0, 5);
`endif

        repeat (4) @(posedge clk); #1;
        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("res_q_empty", res_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
